axi_lite_sram_responder: RTL and testbench
==========================================

// Module: axi_lite_sram_responder
// PURPOSE
//  AXI4-Lite-style SRAM responder: the memory-side end of the LSU's AR/R and AW/W/B handshakes.
//  Holds a word-addressed 32-bit array and services one read and one write transaction independently.
//  Response latency is either fixed or LFSR-randomised, to stress the LSU's handshake logic in simulation.
// PARAMETERS
//  DEPTH_LOG2   10            log2 of word count; array is 2**DEPTH_LOG2 x 32 bits
//  BASE_ADDR    32'h8000_0000 byte address of word 0
//  RAND_LAT     1             1: LFSR latency 1..2**LAT_BITS; 0: fixed latency FIX_LAT
//  LAT_BITS     2             width of the random latency field
//  FIX_LAT      1             fixed latency in cycles (>=1), used when RAND_LAT=0
//  LFSR_SEED    8'hA5         non-zero seed for the latency LFSR
// PORTS
//  clk      in   1   clock
//  rst      in   1   asynchronous reset, active-low
//  araddr   in   32  read byte address
//  arvalid  in   1   read address valid
//  arready  out  1   read address accepted
//  rdata    out  32  read data
//  rresp    out  2   2'b00 OKAY, 2'b11 DECERR
//  rvalid   out  1   read data valid
//  rready   in   1   LSU ready for read data
//  awaddr   in   32  write byte address
//  awvalid  in   1   write address valid
//  awready  out  1   write address accepted
//  wdata    in   32  write data
//  wstrb    in   8   byte strobes; bits[3:0] used, bits[7:4] ignored
//  wvalid   in   1   write data valid
//  wready   out  1   write data accepted
//  bresp    out  2   2'b00 OKAY, 2'b11 DECERR
//  bvalid   out  1   write response valid
//  bready   in   1   LSU ready for write response
// BEHAVIOUR
//  Reset (rst=0, async): arready=1, awready=1, wready=1; rvalid=0, bvalid=0; rdata=0, rresp=0, bresp=0.
//   Both FSMs enter IDLE; latched addresses/data are dropped; array contents are NOT cleared.
//  In range: BASE_ADDR <= addr < BASE_ADDR+4*2**DEPTH_LOG2. Word index = (addr-BASE_ADDR)[DEPTH_LOG2+1:2].
//   addr[1:0] is ignored (no misalignment error).
//  Read FSM: R_IDLE -> R_WAIT -> R_RESP -> R_IDLE.
//   R_IDLE: arready=1. On arvalid, latch araddr, load the delay counter, go to R_WAIT, arready<=0.
//   R_WAIT: count down; on reaching 0, register rdata/rresp from the array, rvalid<=1, go to R_RESP.
//   R_RESP: hold rvalid, rdata and rresp stable until rvalid&rready; then rvalid<=0, arready<=1, R_IDLE.
//   Out of range: rdata=0, rresp=DECERR.
//   Minimum AR-accept to rvalid is latency+1 cycles.
//  Write FSM: W_IDLE -> W_WAIT -> W_RESP -> W_IDLE.
//   In W_IDLE, AW and W are captured independently in either order or in the same cycle.
//   awready drops the cycle after its handshake; wready likewise.
//   When both are captured, load the delay counter and go to W_WAIT.
//   W_WAIT: on count 0, apply the write: byte i is written iff wstrb[i], for i=0..3.
//   Then bvalid<=1 and go to W_RESP.
//   wstrb[3:0]=0 writes nothing, bresp=OKAY. Out of range: no write, bresp=DECERR.
//   W_RESP: hold bvalid and bresp until bvalid&bready; then awready<=1, wready<=1, W_IDLE.
//  Latency: RAND_LAT=1 uses LFSR[LAT_BITS-1:0]+1 sampled at load; RAND_LAT=0 uses FIX_LAT.
//   The LFSR advances every cycle out of reset and is shared by both FSMs.
//  Same-address read and write in flight together: the read returns the array value at its R_WAIT expiry.
//   If the write applies in that same cycle, the read returns the OLD data (read-before-write).
//  Back-to-back transactions: a new AR is accepted no earlier than the cycle after an R handshake.
//   The same rule applies to AW/W after a B handshake.
//  VALID signals never depend combinationally on READY inputs; all outputs are registered.
// STRUCTURE
//  Shared package: response codes (RESP_OKAY, RESP_DECERR), read/write FSM state encodings.
//  Sub-module lat_lfsr (8-bit Galois LFSR, taps 8,6,5,4; seed parameter; async active-low reset).
//   It outputs its current value; the parent slices LAT_BITS.
//  Array is a plain reg array with per-byte write enables. No reset of array contents.
// TESTING
//  1. RAND_LAT=0, FIX_LAT=2: write 0xDEADBEEF to 0x8000_0010 with wstrb=0x0F, then read it.
//     -> bvalid 3 cycles after the second of AW/W; rdata=0xDEADBEEF, rresp=0.
//  2. Partial write: wstrb=0x02, wdata=0x0000_5500 to the same word.
//     -> the read returns 0xDEAD55EF; wstrb=0xF0 leaves it unchanged.
//  3. AW presented 3 cycles before W, then W before AW.
//     -> exactly one write and one bvalid per transaction; ready drops only after each handshake.
//  4. Hold rready=0 for 5 cycles with rvalid=1.
//     -> rdata and rvalid stay stable, arready stays 0, and no second AR is accepted.
//  5. Read 0x7FFF_FFFC and write 0x8000_1000 (DEPTH_LOG2=10).
//     -> rresp=3 with rdata=0; bresp=3; array unchanged.
//  6. Assert rst low mid-W_WAIT, then release.
//     -> bvalid=0 and the ready signals are 1 immediately; no write occurs.
//     -> A subsequent RAND_LAT=1 run of 200 mixed transactions matches a reference memory model.

Source files
------------

// File: rtl/axi_lite_sram_responder_pkg.sv
// Shared types and helpers for the AXI4-Lite SRAM responder.
package axi_lite_sram_responder_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Width of the latency down-counters; wide enough for any LAT_BITS<=7 or FIX_LAT<=255.
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_WAIT = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    // Unsigned wrap-around makes addresses below the base land far out of range.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input int unsigned depth_log2);
        logic [31:0] off;
        off = addr - base;
        return off < (32'd4 << depth_log2);
    endfunction

endpackage

// File: rtl/axi_lite_sram_responder_lat_lfsr.sv
// 8-bit Galois LFSR (x^8+x^6+x^5+x^4+1) that free-runs to randomise response latency.
module lat_lfsr #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] lfsr_o
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    // Right-shift Galois step: feed the output bit back into the tap positions.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[7:1]};
        if (lfsr_q[0]) begin
            lfsr_d = lfsr_d ^ 8'hB8;
        end
    end

    // State register; a non-zero seed keeps the sequence out of the all-zero lock-up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/axi_lite_sram_responder.sv
// Memory-side AXI4-Lite responder: independent read and write FSMs over a word array.
module axi_lite_sram_responder
    import axi_lite_sram_responder_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter bit          RAND_LAT   = 1'b1,
    parameter int unsigned LAT_BITS   = 2,
    parameter int unsigned FIX_LAT    = 1,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] araddr_i,
    input  logic        arvalid_i,
    output logic        arready_o,
    output logic [31:0] rdata_o,
    output logic [1:0]  rresp_o,
    output logic        rvalid_o,
    input  logic        rready_i,
    input  logic [31:0] awaddr_i,
    input  logic        awvalid_i,
    output logic        awready_o,
    input  logic [31:0] wdata_i,
    input  logic [7:0]  wstrb_i,
    input  logic        wvalid_i,
    output logic        wready_o,
    output logic [1:0]  bresp_o,
    output logic        bvalid_o,
    input  logic        bready_i
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [31:0] mem [DEPTH];

    logic [7:0]       lfsr_val;
    logic [CNT_W-1:0] lat_load;
    logic             unused_bits;

    rd_state_e        rstate_q, rstate_d;
    logic [CNT_W-1:0] rcnt_q, rcnt_d;
    logic [31:0]      araddr_q, araddr_d;
    logic             arready_q, arready_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [1:0]       rresp_q, rresp_d;
    logic             rvalid_q, rvalid_d;

    wr_state_e        wstate_q, wstate_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic [31:0]      awaddr_q, awaddr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic             aw_have_q, aw_have_d;
    logic             w_have_q, w_have_d;
    logic             awready_q, awready_d;
    logic             wready_q, wready_d;
    logic [1:0]       bresp_q, bresp_d;
    logic             bvalid_q, bvalid_d;

    logic                  rd_in_range, wr_in_range, mem_we;
    logic [DEPTH_LOG2-1:0] rd_idx, wr_idx;

    lat_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .lfsr_o (lfsr_val)
    );

    // Upper strobe bits and the LFSR bits beyond the latency field are don't-cares.
    assign unused_bits = ^{wstrb_i[7:4], lfsr_val};

    assign rd_in_range = addr_in_range(araddr_q, BASE_ADDR, DEPTH_LOG2);
    assign wr_in_range = addr_in_range(awaddr_q, BASE_ADDR, DEPTH_LOG2);
    assign rd_idx      = DEPTH_LOG2'((araddr_q - BASE_ADDR) >> 2);
    assign wr_idx      = DEPTH_LOG2'((awaddr_q - BASE_ADDR) >> 2);

    // Latency value sampled whenever either FSM loads its counter.
    always_comb begin
        if (RAND_LAT) begin
            lat_load = CNT_W'(lfsr_val[LAT_BITS-1:0]) + CNT_W'(1);
        end else begin
            lat_load = CNT_W'(FIX_LAT);
        end
    end

    // Read FSM next-state: accept AR, wait out the latency, hold the response until taken.
    always_comb begin
        rstate_d  = rstate_q;
        rcnt_d    = rcnt_q;
        araddr_d  = araddr_q;
        arready_d = arready_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rvalid_d  = rvalid_q;
        unique case (rstate_q)
            R_IDLE: begin
                if (arvalid_i && arready_q) begin
                    araddr_d  = araddr_i;
                    rcnt_d    = lat_load;
                    arready_d = 1'b0;
                    rstate_d  = R_WAIT;
                end
            end
            R_WAIT: begin
                if (rcnt_q == '0) begin
                    rdata_d  = rd_in_range ? mem[rd_idx] : '0;
                    rresp_d  = rd_in_range ? RESP_OKAY : RESP_DECERR;
                    rvalid_d = 1'b1;
                    rstate_d = R_RESP;
                end else begin
                    rcnt_d = rcnt_q - CNT_W'(1);
                end
            end
            R_RESP: begin
                if (rready_i) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    rstate_d  = R_IDLE;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    // Write FSM next-state: collect AW and W in any order, wait, commit, then respond.
    always_comb begin
        wstate_d  = wstate_q;
        wcnt_d    = wcnt_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_have_d = aw_have_q;
        w_have_d  = w_have_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bresp_d   = bresp_q;
        bvalid_d  = bvalid_q;
        mem_we    = 1'b0;
        unique case (wstate_q)
            W_IDLE: begin
                if (awvalid_i && awready_q) begin
                    awaddr_d  = awaddr_i;
                    aw_have_d = 1'b1;
                    awready_d = 1'b0;
                end
                if (wvalid_i && wready_q) begin
                    wdata_d  = wdata_i;
                    wstrb_d  = wstrb_i[3:0];
                    w_have_d = 1'b1;
                    wready_d = 1'b0;
                end
                if (aw_have_d && w_have_d) begin
                    wcnt_d   = lat_load;
                    wstate_d = W_WAIT;
                end
            end
            W_WAIT: begin
                if (wcnt_q == '0) begin
                    mem_we   = wr_in_range;
                    bresp_d  = wr_in_range ? RESP_OKAY : RESP_DECERR;
                    bvalid_d = 1'b1;
                    wstate_d = W_RESP;
                end else begin
                    wcnt_d = wcnt_q - CNT_W'(1);
                end
            end
            W_RESP: begin
                if (bready_i) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    aw_have_d = 1'b0;
                    w_have_d  = 1'b0;
                    wstate_d  = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    // State and handshake registers for both FSMs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rstate_q  <= R_IDLE;
            rcnt_q    <= '0;
            araddr_q  <= '0;
            arready_q <= 1'b1;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            wstate_q  <= W_IDLE;
            wcnt_q    <= '0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_have_q <= 1'b0;
            w_have_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            bresp_q   <= RESP_OKAY;
            bvalid_q  <= 1'b0;
        end else begin
            rstate_q  <= rstate_d;
            rcnt_q    <= rcnt_d;
            araddr_q  <= araddr_d;
            arready_q <= arready_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rvalid_q  <= rvalid_d;
            wstate_q  <= wstate_d;
            wcnt_q    <= wcnt_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_have_q <= aw_have_d;
            w_have_q  <= w_have_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bresp_q   <= bresp_d;
            bvalid_q  <= bvalid_d;
        end
    end

    // Byte-lane writes into the array; contents survive reset by design.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_we && wstrb_q[b]) begin
                mem[wr_idx][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

    assign arready_o = arready_q;
    assign rdata_o   = rdata_q;
    assign rresp_o   = rresp_q;
    assign rvalid_o  = rvalid_q;
    assign awready_o = awready_q;
    assign wready_o  = wready_q;
    assign bresp_o   = bresp_q;
    assign bvalid_o  = bvalid_q;

endmodule

// File: tb/tb_axi_lite_sram_responder.sv
// Bench: index 0 is a fixed-latency (2) responder, index 1 a randomised-latency one.
module tb_axi_lite_sram_responder;

    localparam int N = 2;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] araddr [N];
    logic        arvalid[N];
    logic        arready[N];
    logic [31:0] rdata  [N];
    logic [1:0]  rresp  [N];
    logic        rvalid [N];
    logic        rready [N];
    logic [31:0] awaddr [N];
    logic        awvalid[N];
    logic        awready[N];
    logic [31:0] wdata  [N];
    logic [7:0]  wstrb  [N];
    logic        wvalid [N];
    logic        wready [N];
    logic [1:0]  bresp  [N];
    logic        bvalid [N];
    logic        bready [N];

    axi_lite_sram_responder #(.RAND_LAT(1'b0), .FIX_LAT(2)) dut_fix (
        .clk(clk), .rst_n(rst_n),
        .araddr_i(araddr[0]), .arvalid_i(arvalid[0]), .arready_o(arready[0]),
        .rdata_o(rdata[0]), .rresp_o(rresp[0]), .rvalid_o(rvalid[0]), .rready_i(rready[0]),
        .awaddr_i(awaddr[0]), .awvalid_i(awvalid[0]), .awready_o(awready[0]),
        .wdata_i(wdata[0]), .wstrb_i(wstrb[0]), .wvalid_i(wvalid[0]), .wready_o(wready[0]),
        .bresp_o(bresp[0]), .bvalid_o(bvalid[0]), .bready_i(bready[0])
    );

    axi_lite_sram_responder #(.RAND_LAT(1'b1)) dut_rnd (
        .clk(clk), .rst_n(rst_n),
        .araddr_i(araddr[1]), .arvalid_i(arvalid[1]), .arready_o(arready[1]),
        .rdata_o(rdata[1]), .rresp_o(rresp[1]), .rvalid_o(rvalid[1]), .rready_i(rready[1]),
        .awaddr_i(awaddr[1]), .awvalid_i(awvalid[1]), .awready_o(awready[1]),
        .wdata_i(wdata[1]), .wstrb_i(wstrb[1]), .wvalid_i(wvalid[1]), .wready_o(wready[1]),
        .bresp_o(bresp[1]), .bvalid_o(bvalid[1]), .bready_i(bready[1])
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One read transaction; lat counts edges from the AR handshake edge to rvalid.
    task automatic do_read(input int k, input logic [31:0] addr, input int rdy_dly,
                           output logic [31:0] data, output logic [1:0] resp, output int lat);
        bit hs = 0;
        int n = 0;
        araddr[k]  = addr;
        arvalid[k] = 1'b1;
        while (!hs && n < 20) begin
            hs = arready[k];
            tick();
            n++;
        end
        arvalid[k] = 1'b0;
        if (!hs) chk("ar_handshake_timeout", 32'd0, 32'd1);
        lat = 0;
        while (!rvalid[k] && lat < 40) begin
            tick();
            lat++;
        end
        if (!rvalid[k]) chk("rvalid_timeout", 32'd0, 32'd1);
        repeat (rdy_dly) tick();
        data = rdata[k];
        resp = rresp[k];
        rready[k] = 1'b1;
        tick();
        rready[k] = 1'b0;
        chk("rvalid_after_r_hs", rvalid[k], 1'b0);
        chk("arready_after_r_hs", arready[k], 1'b1);
    endtask

    // One write transaction with AW offered at cycle aw_d and W at w_d; lat counts
    // edges from the later of the two handshakes to bvalid.
    task automatic do_write(input int k, input logic [31:0] addr, input logic [31:0] data,
                            input logic [7:0] strb, input int aw_d, input int w_d,
                            input int b_dly, output logic [1:0] resp, output int lat,
                            output int ready_bad);
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        int t = 0;
        ready_bad = 0;
        awaddr[k] = addr;
        wdata[k]  = data;
        wstrb[k]  = strb;
        while (!(aw_done && w_done) && t < 40) begin
            awvalid[k] = !aw_done && (t >= aw_d);
            wvalid[k]  = !w_done && (t >= w_d);
            if (aw_done == awready[k]) ready_bad++;
            if (w_done == wready[k]) ready_bad++;
            aw_hs = awvalid[k] && awready[k];
            w_hs  = wvalid[k] && wready[k];
            tick();
            aw_done |= aw_hs;
            w_done  |= w_hs;
            t++;
        end
        awvalid[k] = 1'b0;
        wvalid[k]  = 1'b0;
        if (!(aw_done && w_done)) chk("aw_w_handshake_timeout", 32'd0, 32'd1);
        lat = 0;
        while (!bvalid[k] && lat < 40) begin
            if (awready[k] || wready[k]) ready_bad++;
            tick();
            lat++;
        end
        if (!bvalid[k]) chk("bvalid_timeout", 32'd0, 32'd1);
        repeat (b_dly) tick();
        resp = bresp[k];
        bready[k] = 1'b1;
        tick();
        bready[k] = 1'b0;
        chk("bvalid_after_b_hs", bvalid[k], 1'b0);
        chk("ready_after_b_hs", {awready[k], wready[k]}, 2'b11);
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [7:0]  strb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                                input logic [7:0] strb, input logic [1:0] er,
                                input logic [31:0] ed);
        vec_t v;
        v.wr = wr; v.addr = addr; v.data = data; v.strb = strb;
        v.exp_resp = er; v.exp_rdata = ed;
        return v;
    endfunction

    // Reference memory for the random run: per-word value plus which bytes are known.
    logic [31:0] mdl  [1024];
    logic [3:0]  known[1024];

    initial begin
        logic [31:0] d, d0, a, m, off;
        logic [1:0]  r;
        int          lat, bad;

        for (int k = 0; k < N; k++) begin
            araddr[k] = '0; arvalid[k] = 1'b0; rready[k] = 1'b0;
            awaddr[k] = '0; awvalid[k] = 1'b0; wdata[k] = '0; wstrb[k] = '0;
            wvalid[k] = 1'b0; bready[k] = 1'b0;
        end
        for (int i = 0; i < 1024; i++) begin
            mdl[i] = '0;
            known[i] = '0;
        end

        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            chk("reset_readys", {arready[k], awready[k], wready[k]}, 3'b111);
            chk("reset_valids", {rvalid[k], bvalid[k]}, 2'b00);
            chk("reset_rdata", rdata[k], 32'd0);
            chk("reset_resps", {rresp[k], bresp[k]}, 4'd0);
        end
        rst_n = 1'b1;
        tick();

        // Directed table on the fixed-latency instance.
        vecs.push_back(mk(1, 32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, 2'd0, 32'h0));
        vecs.push_back(mk(0, 32'h8000_0010, 32'h0, 8'h00, 2'd0, 32'hDEAD_BEEF));
        vecs.push_back(mk(1, 32'h8000_0010, 32'h0000_5500, 8'h02, 2'd0, 32'h0));
        vecs.push_back(mk(0, 32'h8000_0010, 32'h0, 8'h00, 2'd0, 32'hDEAD_55EF));
        vecs.push_back(mk(1, 32'h8000_0010, 32'hFFFF_FFFF, 8'hF0, 2'd0, 32'h0));
        vecs.push_back(mk(0, 32'h8000_0010, 32'h0, 8'h00, 2'd0, 32'hDEAD_55EF));
        vecs.push_back(mk(1, 32'h8000_0010, 32'h1234_5678, 8'h00, 2'd0, 32'h0));
        vecs.push_back(mk(0, 32'h8000_0012, 32'h0, 8'h00, 2'd0, 32'hDEAD_55EF));
        vecs.push_back(mk(1, 32'h8000_0000, 32'hCAFE_F00D, 8'h0F, 2'd0, 32'h0));
        vecs.push_back(mk(0, 32'h7FFF_FFFC, 32'h0, 8'h00, 2'd3, 32'h0));
        vecs.push_back(mk(1, 32'h8000_1000, 32'h1111_1111, 8'h0F, 2'd3, 32'h0));
        vecs.push_back(mk(0, 32'h8000_0000, 32'h0, 8'h00, 2'd0, 32'hCAFE_F00D));
        vecs.push_back(mk(1, 32'h8000_0FFF, 32'hA5A5_5A5A, 8'h0F, 2'd0, 32'h0));
        vecs.push_back(mk(0, 32'h8000_0FFC, 32'h0, 8'h00, 2'd0, 32'hA5A5_5A5A));
        vecs.push_back(mk(0, 32'h8000_1000, 32'h0, 8'h00, 2'd3, 32'h0));

        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                do_write(0, vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0, i % 3, r, lat, bad);
                $display("[TB] vec %0d W addr=%h data=%h strb=%h bresp=%0d lat=%0d",
                         i, vecs[i].addr, vecs[i].data, vecs[i].strb, r, lat);
                chk("vec_bresp", r, vecs[i].exp_resp);
                chk("vec_write_ready_protocol", bad, 0);
            end else begin
                do_read(0, vecs[i].addr, i % 3, d, r, lat);
                $display("[TB] vec %0d R addr=%h rdata=%h rresp=%0d lat=%0d",
                         i, vecs[i].addr, d, r, lat);
                chk("vec_rdata", d, vecs[i].exp_rdata);
                chk("vec_rresp", r, vecs[i].exp_resp);
            end
            chk("vec_fixed_latency", lat, 3);
        end

        // AW three cycles ahead of W, then W three cycles ahead of AW.
        do_write(0, 32'h8000_0020, 32'h0102_0304, 8'h0F, 0, 3, 0, r, lat, bad);
        $display("[TB] seq AW-first bresp=%0d lat=%0d ready_bad=%0d", r, lat, bad);
        chk("awfirst_ready_protocol", bad, 0);
        chk("awfirst_lat", lat, 3);
        repeat (3) begin
            tick();
            chk("awfirst_single_bvalid", bvalid[0], 1'b0);
        end
        do_write(0, 32'h8000_0024, 32'h0506_0708, 8'h0F, 3, 0, 1, r, lat, bad);
        $display("[TB] seq W-first bresp=%0d lat=%0d ready_bad=%0d", r, lat, bad);
        chk("wfirst_ready_protocol", bad, 0);
        chk("wfirst_lat", lat, 3);
        tick();
        chk("wfirst_single_bvalid", bvalid[0], 1'b0);
        do_read(0, 32'h8000_0020, 0, d, r, lat);
        chk("awfirst_readback", d, 32'h0102_0304);
        do_read(0, 32'h8000_0024, 0, d, r, lat);
        chk("wfirst_readback", d, 32'h0506_0708);

        // Response stall: rready low for 5 cycles with a second AR pending.
        araddr[0] = 32'h8000_0010;
        arvalid[0] = 1'b1;
        tick();
        araddr[0] = 32'h8000_0000;
        lat = 0;
        while (!rvalid[0] && lat < 40) begin
            chk("stall_no_second_ar", arready[0], 1'b0);
            tick();
            lat++;
        end
        d0 = rdata[0];
        chk("stall_first_rdata", d0, 32'hDEAD_55EF);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("stall_rvalid_held", rvalid[0], 1'b1);
            chk("stall_rdata_held", rdata[0], d0);
            chk("stall_arready_low", arready[0], 1'b0);
        end
        $display("[TB] seq stall rdata=%h held 5 cycles", d0);
        rready[0] = 1'b1;
        arvalid[0] = 1'b0;
        tick();
        rready[0] = 1'b0;
        chk("stall_rvalid_drop", rvalid[0], 1'b0);
        chk("stall_arready_back", arready[0], 1'b1);

        // Reset asserted while a write is waiting out its latency.
        awaddr[0] = 32'h8000_0010; wdata[0] = 32'hFFFF_FFFF; wstrb[0] = 8'h0F;
        awvalid[0] = 1'b1; wvalid[0] = 1'b1;
        tick();
        awvalid[0] = 1'b0; wvalid[0] = 1'b0;
        chk("rstmid_in_wait", {awready[0], wready[0], bvalid[0]}, 3'b000);
        tick();
        rst_n = 1'b0;
        #1;
        chk("rstmid_readys_now", {arready[0], awready[0], wready[0]}, 3'b111);
        chk("rstmid_bvalid_now", bvalid[0], 1'b0);
        tick();
        rst_n = 1'b1;
        repeat (4) begin
            tick();
            chk("rstmid_no_bvalid", bvalid[0], 1'b0);
        end
        do_read(0, 32'h8000_0010, 0, d, r, lat);
        $display("[TB] seq reset-mid-write readback=%h", d);
        chk("rstmid_no_write", d, 32'hDEAD_55EF);

        // Randomised run against the reference memory on the random-latency instance.
        for (int i = 0; i < 200; i++) begin
            int sel;
            bit wr;
            logic [7:0] s;
            sel = $urandom_range(0, 19);
            if (sel == 0)      a = BASE + 32'h1000 + 32'($urandom_range(0, 255));
            else if (sel == 1) a = BASE - 32'd4 * 32'($urandom_range(1, 64));
            else if (sel == 2) a = BASE + 32'h0FFC + 32'($urandom_range(0, 3));
            else               a = BASE + 32'd4 * 32'($urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            off = a - BASE;
            wr = $urandom_range(0, 1) == 1;
            if (wr) begin
                d = $urandom;
                s = 8'($urandom);
                do_write(1, a, d, s, $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 3), r, lat, bad);
                $display("[TB] rnd %0d W addr=%h data=%h strb=%h bresp=%0d lat=%0d",
                         i, a, d, s, r, lat);
                chk("rnd_bresp", r, (off < 32'h1000) ? 2'd0 : 2'd3);
                chk("rnd_write_ready_protocol", bad, 0);
                if (off < 32'h1000) begin
                    for (int b = 0; b < 4; b++) begin
                        if (s[b]) begin
                            mdl[off[11:2]][8*b +: 8] = d[8*b +: 8];
                            known[off[11:2]][b] = 1'b1;
                        end
                    end
                end
            end else begin
                do_read(1, a, $urandom_range(0, 3), d, r, lat);
                $display("[TB] rnd %0d R addr=%h rdata=%h rresp=%0d lat=%0d",
                         i, a, d, r, lat);
                if (off < 32'h1000) begin
                    m = {{8{known[off[11:2]][3]}}, {8{known[off[11:2]][2]}},
                         {8{known[off[11:2]][1]}}, {8{known[off[11:2]][0]}}};
                    chk("rnd_rresp", r, 2'd0);
                    chk("rnd_rdata", d & m, mdl[off[11:2]] & m);
                end else begin
                    chk("rnd_rresp", r, 2'd3);
                    chk("rnd_rdata_decerr", d, 32'd0);
                end
            end
            chk("rnd_latency_range", (lat >= 2 && lat <= 5), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
